toggle_cover_sampler: RTL and testbench
=======================================

# toggle_cover_sampler

Upstream feeder for the per-group toggle coverage reporters. Samples a WIDTH-bit design signal on gbl_clk and detects rising and falling transitions per bit. Emits one-cycle, registered `valid` pulses in the 2-bits-per-signal-bit layout the reporters consume. Keeps a sticky seen-bitmap so each cover point can be reported once, and exposes a distinct-hit count for bench-level closure checks.

## Interface
- `WIDTH`, default 1: number of monitored signal bits; produces 2*WIDTH cover points.
- `FIRST_HIT_ONLY`, default 1: 1 = pulse a cover point only on its first hit since reset/clear; 0 = pulse on every transition.
- `SETTLE_CYCLES`, default 2: cycles after reset release during which transitions are ignored; legal range 1..15.
- `gbl_clk` in 1: sampling clock.
- `reset` in 1: reset, synchronous, active-low.
- `enable` in 1: detection enable; low pauses detection only.
- `clear` in 1: synchronous clear of the seen-bitmap and hit count.
- `sig` in WIDTH: monitored signal.
- `valid` out 2*WIDTH: `valid[2i]` = bit i rose; `valid[2i+1]` = bit i fell.
- `hit_count` out $clog2(2*WIDTH+1): number of distinct cover points seen.
- `all_hit` out 1: high when `hit_count` == 2*WIDTH.

## Operation
- Registers: `prev` (WIDTH), `seen` (2*WIDTH), `valid` (2*WIDTH), `hit_count`, settle counter (4 bits), state.
- States:
  - RST: entered while `reset` = 0.
  - SETTLE: counts SETTLE_CYCLES cycles, then moves to ARMED.
  - ARMED: detects transitions; moves to PAUSED when `enable` = 0.
  - PAUSED: returns to ARMED when `enable` = 1.
- `prev` loads `sig` every cycle in every state except RST, including SETTLE and PAUSED. Re-enabling after a pause therefore never reports a stale toggle.
- Raw event, ARMED only:
  - rise[i] = `sig[i]` & ~`prev[i]`
  - fall[i] = ~`sig[i]` & `prev[i]`
- Filtered event: ev = raw & ~`seen` when FIRST_HIT_ONLY = 1, else ev = raw.
- Next `valid` = ev (registered). In any non-ARMED state, next `valid` = 0.
- `seen` |= raw on every ARMED cycle.
- `hit_count` += popcount(raw & ~`seen`), so it counts distinct points regardless of FIRST_HIT_ONLY and never exceeds 2*WIDTH.
- `clear` = 1:
  - `seen` and `hit_count` go to 0 next cycle.
  - Events in the same cycle are dropped: no `valid` pulse, no `seen` update.
  - `clear` has priority over detection.
  - `prev` still loads `sig`.
- Reset values: `valid` = 0, `seen` = 0, `hit_count` = 0, `all_hit` = 0, `prev` = 0, state RST. In RST `prev` is held at 0.
- `reset` = 0 mid-operation: everything returns to reset values on the next edge. Any pulse in flight is dropped. Settling restarts from the full count after release.
- Rise and fall of different bits in the same cycle are reported in parallel, with no arbitration or back-pressure. Rise and fall of the same bit in the same cycle is impossible.

## Timing
- Edge-to-report latency: 1 cycle. Bit i differs from `prev[i]` in ARMED at edge n, so `valid` is high during cycle n+1 for exactly one cycle.
- First detectable transition: sampled at the (SETTLE_CYCLES+1)-th edge after `reset` returns high. Transitions at earlier edges are absorbed into `prev`.
- `hit_count` and `all_hit` update in the same cycle that the corresponding `valid` rises.
- `enable` low at edge n: a transition at edge n is not reported.
- `all_hit` is combinational from `hit_count`. All other outputs are registered.

## Structure
- Shared package `toggle_cov_pkg`:
  - state enum `tcs_state_e` {RST, SETTLE, ARMED, PAUSED}
  - localparam `TCS_SETTLE_W` = 4
  - function `cover_idx(bit, dir)` = 2*bit + dir, shared with the reporter wrappers.
- One natural sub-module: `tcs_popcount`, a parameterised popcount used for the `hit_count` increment.
- The detection datapath is a generate loop per bit; no other hierarchy.

## Test plan
- WIDTH = 1, SETTLE_CYCLES = 2: release reset with `sig` = 1, toggle `sig` 1→0 at the 3rd edge → `valid` = 2'b10 for one cycle; `hit_count` = 1.
- WIDTH = 1, FIRST_HIT_ONLY = 1: toggle `sig` 0→1→0→1 → exactly one pulse each on `valid[0]` and `valid[1]`; `hit_count` = 2, `all_hit` = 1. Repeat with FIRST_HIT_ONLY = 0 → three pulses.
- WIDTH = 4: `sig` 4'b0000→4'b1010 in one cycle → `valid` = 8'b01000100 (rise of bits 1 and 3 → points 2 and 6); `hit_count` = 2.
- `enable` = 0 while `sig` 0→1, then `enable` = 1 → no pulse; next fall → `valid[1]` pulse.
- `clear` asserted in the same cycle as a 0→1 transition → no pulse, `hit_count` = 0. The next rise → `valid[0]` pulse.
- `reset` asserted one cycle after a transition → pulse suppressed, all outputs 0. The settle window restarts: a toggle at the 1st edge after release is not reported.

Source files
------------

// File: rtl/toggle_cov_pkg.sv
// Shared types and helpers for the toggle coverage sampler and the reporter wrappers.
// Cover point layout: 2*bit + dir, where dir 0 = rise and dir 1 = fall.
package toggle_cov_pkg;

    typedef enum logic [1:0] {
        RST,
        SETTLE,
        ARMED,
        PAUSED
    } tcs_state_e;

    localparam int TCS_SETTLE_W = 4;

    function automatic int unsigned cover_idx(input int unsigned bit_idx, input logic dir);
        return 2 * bit_idx + int'(dir);
    endfunction

endpackage

// File: rtl/tcs_popcount.sv
// Parameterised population count of an N-bit vector.
module tcs_popcount #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/toggle_cover_sampler.sv
// Per-bit rise/fall detector feeding the toggle coverage reporters: one-cycle valid pulses,
// a sticky seen-bitmap and a distinct-hit count.
module toggle_cover_sampler
    import toggle_cov_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int FIRST_HIT_ONLY = 1,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                           gbl_clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               sig,
    output logic [2*WIDTH-1:0]             valid,
    output logic [$clog2(2*WIDTH+1)-1:0]   hit_count,
    output logic                           all_hit
);

    localparam int NPTS  = 2 * WIDTH;
    localparam int CNT_W = $clog2(2 * WIDTH + 1);

    tcs_state_e              state_q, state_d;
    logic [TCS_SETTLE_W-1:0] settle_q, settle_d, settle_inc;
    logic [WIDTH-1:0]        prev_q, prev_d;
    logic [NPTS-1:0]         seen_q, seen_d;
    logic [NPTS-1:0]         valid_q, valid_d;
    logic [CNT_W-1:0]        hit_q, hit_d;
    logic [NPTS-1:0]         raw;
    logic [NPTS-1:0]         new_hits;
    logic [CNT_W-1:0]        new_cnt;
    logic                    detect;

    assign detect = (state_q == ARMED) && enable;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign raw[cover_idx(gi, 1'b0)] = detect &  sig[gi] & ~prev_q[gi];
            assign raw[cover_idx(gi, 1'b1)] = detect & ~sig[gi] &  prev_q[gi];
        end
    endgenerate

    assign new_hits = raw & ~seen_q;

    tcs_popcount #(
        .N  (NPTS),
        .CW (CNT_W)
    ) u_popcount (
        .bits_i  (new_hits),
        .count_o (new_cnt)
    );

    // The release edge itself counts as the first settle cycle.
    assign settle_inc = settle_q + TCS_SETTLE_W'(1);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            RST: begin
                settle_d = TCS_SETTLE_W'(1);
                state_d  = (SETTLE_CYCLES <= 1) ? ARMED : SETTLE;
            end
            SETTLE: begin
                settle_d = settle_inc;
                if (int'(settle_inc) >= SETTLE_CYCLES) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (enable) begin
                    state_d = ARMED;
                end
            end
            default: state_d = RST;
        endcase
        if (!reset) begin
            state_d  = RST;
            settle_d = '0;
        end
    end

    always_comb begin
        prev_d  = sig;
        seen_d  = seen_q | raw;
        hit_d   = hit_q + new_cnt;
        valid_d = (FIRST_HIT_ONLY != 0) ? new_hits : raw;
        if (clear) begin
            seen_d  = '0;
            hit_d   = '0;
            valid_d = '0;
        end
        if (!reset) begin
            prev_d  = '0;
            seen_d  = '0;
            hit_d   = '0;
            valid_d = '0;
        end
    end

    always_ff @(posedge gbl_clk) begin
        state_q  <= state_d;
        settle_q <= settle_d;
        prev_q   <= prev_d;
        seen_q   <= seen_d;
        hit_q    <= hit_d;
        valid_q  <= valid_d;
    end

    assign valid     = valid_q;
    assign hit_count = hit_q;
    assign all_hit   = (hit_q == CNT_W'(NPTS));

endmodule

// File: tb/tb_toggle_cover_sampler.sv
// Directed bench: three sampler configurations share reset/enable/clear and are checked
// against hand-computed vectors after each clock edge.
module tb_toggle_cover_sampler;

    logic       gbl_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       sig1;
    logic [3:0] sig4;

    logic [1:0] valid_a, valid_b;
    logic [1:0] hit_a, hit_b;
    logic       all_a, all_b;
    logic [7:0] valid_c;
    logic [3:0] hit_c;
    logic       all_c;

    always #5 gbl_clk = ~gbl_clk;

    toggle_cover_sampler #(.WIDTH(1), .FIRST_HIT_ONLY(1), .SETTLE_CYCLES(2)) dut_a (
        .gbl_clk (gbl_clk), .reset (reset), .enable (enable), .clear (clear),
        .sig (sig1), .valid (valid_a), .hit_count (hit_a), .all_hit (all_a)
    );

    toggle_cover_sampler #(.WIDTH(1), .FIRST_HIT_ONLY(0), .SETTLE_CYCLES(2)) dut_b (
        .gbl_clk (gbl_clk), .reset (reset), .enable (enable), .clear (clear),
        .sig (sig1), .valid (valid_b), .hit_count (hit_b), .all_hit (all_b)
    );

    toggle_cover_sampler #(.WIDTH(4), .FIRST_HIT_ONLY(1), .SETTLE_CYCLES(2)) dut_c (
        .gbl_clk (gbl_clk), .reset (reset), .enable (enable), .clear (clear),
        .sig (sig4), .valid (valid_c), .hit_count (hit_c), .all_hit (all_c)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic       s;
        logic [1:0] va;
        logic [1:0] ha;
        logic [1:0] vb;
        logic [1:0] hb;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_c(input logic [3:0] s, input logic [7:0] exp_v, input logic [3:0] exp_h);
        @(negedge gbl_clk);
        sig4 = s;
        @(posedge gbl_clk);
        #1;
        $display("w4 sig=%b valid=%b hit=%0d all=%b", s, valid_c, hit_c, all_c);
        chk("w4_valid", 32'(valid_c), 32'(exp_v));
        chk("w4_hit", 32'(hit_c), 32'(exp_h));
        chk("w4_all_hit", 32'(all_c), 32'(exp_h == 4'd8));
    endtask

    initial begin
        // rst en clr s | va ha | vb hb
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        // release with sig=1, fall at the 3rd edge
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'd1, 2'b10, 2'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'd1, 2'b00, 2'd1};
        // clear, then 0->1->0->1
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 2'b01, 2'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'd2, 2'b10, 2'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd2, 2'b01, 2'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd2, 2'b00, 2'd2};
        // pause: fall with enable low, rise while paused, re-enable, then fall
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'd1, 2'b10, 2'd1};
        // clear coincident with a rise drops it
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'd1, 2'b10, 2'd1};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'd2, 2'b01, 2'd2};
        // reset swallows a transition; settle window restarts
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 2'd0};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 2'b01, 2'd1};

        reset  = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        sig1   = 1'b0;
        sig4   = 4'b0000;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge gbl_clk);
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            clear  = vecs[i].clr;
            sig1   = vecs[i].s;
            @(posedge gbl_clk);
            #1;
            $display("vec %0d rst=%b en=%b clr=%b sig=%b | a valid=%b hit=%0d all=%b | b valid=%b hit=%0d",
                     i, vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].s,
                     valid_a, hit_a, all_a, valid_b, hit_b);
            chk($sformatf("vec%0d_valid_a", i), 32'(valid_a), 32'(vecs[i].va));
            chk($sformatf("vec%0d_hit_a", i), 32'(hit_a), 32'(vecs[i].ha));
            chk($sformatf("vec%0d_all_a", i), 32'(all_a), 32'(vecs[i].ha == 2'd2));
            chk($sformatf("vec%0d_valid_b", i), 32'(valid_b), 32'(vecs[i].vb));
            chk($sformatf("vec%0d_hit_b", i), 32'(hit_b), 32'(vecs[i].hb));
            chk($sformatf("vec%0d_valid_c_idle", i), 32'(valid_c), 32'd0);
        end

        // WIDTH=4 sequence, already armed from the table's last release
        step_c(4'b1010, 8'b0100_0100, 4'd2);
        step_c(4'b1010, 8'b0000_0000, 4'd2);
        step_c(4'b0101, 8'b1001_1001, 4'd6);
        step_c(4'b1111, 8'b0000_0000, 4'd6);
        step_c(4'b0000, 8'b0010_0010, 4'd8);
        step_c(4'b0000, 8'b0000_0000, 4'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
